// File: rtl/alu_mul_seq_if.sv
// Control-unit/ALU bus of the shift-and-add multiply sequencer.
// master: control unit + ALU side; slave: the sequencer itself.
interface alu_mul_seq_if #(
  parameter int WRD_SIZE  = 8,
  parameter int SEL_WIDTH = 3
);
  logic                 start;
  logic [WRD_SIZE-1:0]  op_a;
  logic [WRD_SIZE-1:0]  op_b;
  logic                 busy;
  logic                 done;
  logic [WRD_SIZE-1:0]  result;
  logic [SEL_WIDTH-1:0] alu_sel;
  logic [WRD_SIZE-1:0]  alu_in1;
  logic [WRD_SIZE-1:0]  alu_in2;
  logic [WRD_SIZE-1:0]  alu_out;
  logic                 alu_zero_flg;

  modport master (
    output start, op_a, op_b, alu_out, alu_zero_flg,
    input  busy, done, result, alu_sel, alu_in1, alu_in2
  );

  modport slave (
    input  start, op_a, op_b, alu_out, alu_zero_flg,
    output busy, done, result, alu_sel, alu_in1, alu_in2
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Sequencer driving the shared ALU to form an unsigned WRD_SIZE x WRD_SIZE
// product (mod 2^WRD_SIZE) by shift-and-add. Optional: ALU_MUL_EARLY_EXIT_EN.
module alu_mul_seq #(
  parameter int WRD_SIZE  = 8,
  parameter int SEL_WIDTH = 3
) (
  input logic          clk,
  input logic          rst,
  alu_mul_seq_if.slave bus
);

  localparam int ITER_W = (WRD_SIZE > 1) ? $clog2(WRD_SIZE) : 1;
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(WRD_SIZE - 1);

  localparam logic [SEL_WIDTH-1:0] SEL_NOP = SEL_WIDTH'(0);
  localparam logic [SEL_WIDTH-1:0] SEL_ADD = SEL_WIDTH'(1);
  localparam logic [SEL_WIDTH-1:0] SEL_SLT = SEL_WIDTH'(5);
  localparam logic [SEL_WIDTH-1:0] SEL_SRT = SEL_WIDTH'(6);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACC,
    S_SHL,
    S_SHR,
    S_DONE
  } state_t;

  state_t              state;
  logic [WRD_SIZE-1:0] acc;
  logic [WRD_SIZE-1:0] a;
  logic [WRD_SIZE-1:0] b;
  logic [ITER_W-1:0]   iter;
  logic                busy_q;
  logic                done_q;
  logic [WRD_SIZE-1:0] result_q;
  logic                shr_exit;

`ifdef ALU_MUL_EARLY_EXIT_EN
  // A zero shifted multiplier means no further partial products remain.
  assign shr_exit = (iter == LAST_ITER) || bus.alu_zero_flg;
`else
  logic unused_zero_flg;
  assign unused_zero_flg = bus.alu_zero_flg;
  assign shr_exit        = (iter == LAST_ITER);
`endif

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

  // ALU drive; each ALU result is consumed on the edge that ends the state.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    bus.alu_sel = SEL_NOP;
    bus.alu_in1 = '0;
    bus.alu_in2 = '0;
    case (state)
      S_ACC: begin
        if (b[0]) begin
          bus.alu_sel = SEL_ADD;
          bus.alu_in1 = acc;
          bus.alu_in2 = a;
        end
      end
      S_SHL: begin
        bus.alu_sel = SEL_SLT;
        bus.alu_in1 = a;
        bus.alu_in2 = WRD_SIZE'(1);
      end
      S_SHR: begin
        bus.alu_sel = SEL_SRT;
        bus.alu_in1 = b;
        bus.alu_in2 = WRD_SIZE'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      acc      <= '0;
      a        <= '0;
      b        <= '0;
      iter     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values of the others.
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            a      <= bus.op_a;
            b      <= bus.op_b;
            acc    <= '0;
            iter   <= '0;
            busy_q <= 1'b1;
            state  <= S_ACC;
          end
        end
        S_ACC: begin
          if (b[0]) acc <= bus.alu_out;
          state <= S_SHL;
        end
        S_SHL: begin
          a     <= bus.alu_out;
          state <= S_SHR;
        end
        S_SHR: begin
          b    <= bus.alu_out;
          iter <= iter + 1'b1;
          if (shr_exit) begin
            // acc is final here, so result is already valid in the DONE cycle.
            result_q <= acc;
            done_q   <= 1'b1;
            state    <= S_DONE;
          end else begin
            state <= S_ACC;
          end
        end
        S_DONE: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq: directed cases, abort by reset, and
// randomized operations checked cycle by cycle against an arithmetic model.
module tb_alu_mul_seq;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;
  logic [W-1:0] model_result;

  alu_mul_seq_if #(.WRD_SIZE(W), .SEL_WIDTH(3)) bus ();

  alu_mul_seq #(.WRD_SIZE(W), .SEL_WIDTH(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model of the shared ALU.
  always_comb begin
    case (bus.alu_sel)
      3'd1:    bus.alu_out = bus.alu_in1 + bus.alu_in2;
      3'd5:    bus.alu_out = bus.alu_in1 << bus.alu_in2;
      3'd6:    bus.alu_out = bus.alu_in1 >> bus.alu_in2;
      default: bus.alu_out = '0;
    endcase
  end
  assign bus.alu_zero_flg = (bus.alu_out == '0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_latency(input logic [W-1:0] b);
`ifdef ALU_MUL_EARLY_EXIT_EN
    int k = 1;
    for (int i = 0; i < W; i++) if (b[i]) k = i + 1;
    return 3 * k + 1;
`else
    return 3 * W + 1;
`endif
  endfunction

  // One operation from start acceptance through the IDLE cycle after DONE.
  // Expected ALU traffic is derived from the long-multiplication schedule:
  // iteration i adds (a<<i) when bit i of the multiplier is set.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit keep_start,
                        input logic [W-1:0] next_a, input logic [W-1:0] next_b);
    int lat;
    int prod;
    int i;
    int ph;
    int partial;
    int e_sel, e_in1, e_in2;
    lat  = exp_latency(b);
    prod = (int'(a) * int'(b)) % 256;
    bus.start = 1'b1;
    bus.op_a  = a;
    bus.op_b  = b;
    @(posedge clk);
    #1;
    if (!keep_start) bus.start = 1'b0;
    for (int n = 1; n <= lat + 1; n++) begin
      @(negedge clk);
      e_sel = 0; e_in1 = 0; e_in2 = 0;
      if (n < lat) begin
        i  = (n - 1) / 3;
        ph = (n - 1) % 3;
        partial = 0;
        for (int j = 0; j < i; j++) if (b[j]) partial += int'(a) << j;
        partial = partial % 256;
        if (ph == 0) begin
          if (b[i]) begin
            e_sel = 1; e_in1 = partial; e_in2 = (int'(a) << i) % 256;
          end
        end else if (ph == 1) begin
          e_sel = 5; e_in1 = (int'(a) << i) % 256; e_in2 = 1;
        end else begin
          e_sel = 6; e_in1 = int'(b) >> i; e_in2 = 1;
        end
      end
      check($sformatf("busy n=%0d a=%0d b=%0d", n, a, b), 32'(bus.busy), 32'(n <= lat));
      check($sformatf("done n=%0d a=%0d b=%0d", n, a, b), 32'(bus.done), 32'(n == lat));
      check($sformatf("result n=%0d a=%0d b=%0d", n, a, b), 32'(bus.result),
            (n >= lat) ? 32'(prod) : 32'(model_result));
      check($sformatf("alu_sel n=%0d a=%0d b=%0d", n, a, b), 32'(bus.alu_sel), 32'(e_sel));
      check($sformatf("alu_in1 n=%0d a=%0d b=%0d", n, a, b), 32'(bus.alu_in1), 32'(e_in1));
      check($sformatf("alu_in2 n=%0d a=%0d b=%0d", n, a, b), 32'(bus.alu_in2), 32'(e_in2));
      if (n == 5) begin
        bus.op_a = next_a;
        bus.op_b = next_b;
      end
      if (!keep_start && n <= lat) bus.start = 1'($urandom_range(0, 1));
    end
    if (!keep_start) bus.start = 1'b0;
    model_result = W'(prod);
  endtask

  task automatic check_idle(input string tag);
    check({tag, " busy"}, 32'(bus.busy), 32'd0);
    check({tag, " done"}, 32'(bus.done), 32'd0);
    check({tag, " result"}, 32'(bus.result), 32'(model_result));
    check({tag, " alu_sel"}, 32'(bus.alu_sel), 32'd0);
    check({tag, " alu_in1"}, 32'(bus.alu_in1), 32'd0);
    check({tag, " alu_in2"}, 32'(bus.alu_in2), 32'd0);
  endtask

  initial begin
    int done_cnt;
    bit keep;
    logic [W-1:0] ra, rb;

    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.op_a     = '0;
    bus.op_b     = '0;
    model_result = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("in_reset");
    rst = 1'b0;
    @(negedge clk);
    check_idle("after_reset");

    // Directed cases.
    run_op(8'd13, 8'd11, 1'b0, 8'd1, 8'd2);
    run_op(8'd255, 8'd255, 1'b0, 8'd0, 8'd0);
    run_op(8'd16, 8'd16, 1'b0, 8'd3, 8'd3);
    run_op(8'd200, 8'd0, 1'b0, 8'd77, 8'd99);
    // Held start with operands changed at cycle 5: back-to-back 7*3 then 9*9.
    run_op(8'd7, 8'd3, 1'b1, 8'd9, 8'd9);
    run_op(8'd9, 8'd9, 1'b0, 8'd0, 8'd0);

    // Reset at cycle 10 of 5*5 aborts the operation without a done pulse.
    bus.start = 1'b1;
    bus.op_a  = 8'd5;
    bus.op_b  = 8'd5;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("abort pre-reset busy", 32'(bus.busy), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_result = '0;
    @(negedge clk);
    check_idle("abort");
    done_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    check("abort no_done", 32'(done_cnt), 32'd0);

    // Randomized operations, some back-to-back with held start.
    for (int k = 0; k < 250; k++) begin
      ra   = W'($urandom_range(0, 255));
      rb   = W'($urandom_range(0, 255) >> $urandom_range(0, 7));
      keep = ($urandom_range(0, 3) == 0);
      run_op(ra, rb, keep, W'($urandom), W'($urandom));
    end
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_idle("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
